addr_napot_map_cfg: RTL

Runtime-programmable rule table for the NAPOT address decoder (`addr_decode_napot`). A narrow write port edits a shadow copy of the rule table, and a commit flag swaps it atomically into the active table. The active table drives the decoder's `addr_map_i`. Each write is validated: rule slot, index range and NAPOT mask/base consistency. The block also supplies the decoder's `config_ongoing` qualifier while an edit session is open.

---
 rtl/addr_napot_map_cfg_pkg.sv | 25 ++
 rtl/addr_napot_map_cfg.sv | 137 +++++++++++++
 2 files changed

// File: rtl/addr_napot_map_cfg_pkg.sv
// Shared helpers and default types for the NAPOT rule-table configuration block.
package addr_napot_map_cfg_pkg;

    // Default address type used when the integrator does not override addr_t.
    typedef logic [31:0] dflt_addr_t;

    // Default rule layout: {idx, base, mask}, idx in the most significant bits.
    typedef struct packed {
        int unsigned idx;
        dflt_addr_t  base;
        dflt_addr_t  mask;
    } dflt_rule_t;

    // Bits needed to select one of num_idx items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        int unsigned width;
        if (num_idx > 32'd1) begin
            width = $clog2(num_idx);
        end else begin
            width = 32'd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/addr_napot_map_cfg.sv
// Runtime-programmable rule table for the NAPOT address decoder.
// Beats edit a shadow copy; a commit copies the shadow into the active table
// in one dedicated SWAP cycle so every slot changes on the same edge.
module addr_napot_map_cfg
    import addr_napot_map_cfg_pkg::*;
#(
    parameter int unsigned          NoRules   = 32'd1,
    parameter int unsigned          NoIndices = 32'd1,
    parameter type                  addr_t    = dflt_addr_t,
    parameter type                  rule_t    = dflt_rule_t,
    parameter rule_t [NoRules-1:0]  RstMap    = '0,
    parameter int unsigned          SelWidth  = idx_width(NoRules)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_req_i,
    output logic                    cfg_gnt_o,
    input  logic                    cfg_we_i,
    input  logic [SelWidth-1:0]     cfg_sel_i,
    input  rule_t                   cfg_rule_i,
    input  logic                    cfg_commit_i,
    input  logic                    abort_i,
    output logic                    cfg_err_o,
    output rule_t [NoRules-1:0]     addr_map_o,
    output logic                    config_ongoing_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIRTY = 2'd1,
        ST_SWAP  = 2'd2
    } state_e;

    state_e              state_r, state_s;
    rule_t [NoRules-1:0] shadow_r, shadow_s;
    rule_t [NoRules-1:0] active_r, active_s;
    logic                err_r, err_s;
    logic                ongoing_r, ongoing_s;
    logic                gnt_s;
    logic                accept_s;
    logic                reject_s;

    // A rule is acceptable when it targets an existing slot, carries a legal
    // index, has a mask of leading ones (all-zero mask allowed) and a base
    // with no bits set below the mask.
    function automatic logic rule_ok(input logic [SelWidth-1:0] sel, input rule_t rule);
        addr_t inv_mask;
        logic  ok;
        inv_mask = ~rule.mask;
        ok = 1'b1;
        if (32'(sel) >= NoRules) begin
            ok = 1'b0;
        end else if (rule.idx >= NoIndices) begin
            ok = 1'b0;
        end else if ((inv_mask & (inv_mask + addr_t'(1))) != addr_t'(0)) begin
            ok = 1'b0;
        end else if ((rule.base & inv_mask) != addr_t'(0)) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // Grant is withheld during reset, during the SWAP bubble and while aborting.
    always_comb begin
        gnt_s    = !rst_i && (state_r != ST_SWAP) && !abort_i;
        accept_s = cfg_req_i && gnt_s;
        reject_s = accept_s && cfg_we_i && !rule_ok(cfg_sel_i, cfg_rule_i);
    end

    // Next-state logic: shadow edits, commit and abort handling.
    always_comb begin
        state_s  = state_r;
        shadow_s = shadow_r;
        active_s = active_r;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DIRTY: begin
                if ((state_r == ST_DIRTY) && abort_i) begin
                    shadow_s = active_r;
                    state_s  = ST_IDLE;
                end else if (accept_s) begin
                    if (reject_s) begin
                        err_s = 1'b1;
                    end else begin
                        if (cfg_we_i) begin
                            shadow_s[cfg_sel_i] = cfg_rule_i;
                        end else begin
                            shadow_s = shadow_r;
                        end
                        if (cfg_commit_i) begin
                            state_s = ST_SWAP;
                        end else if (cfg_we_i) begin
                            state_s = ST_DIRTY;
                        end else begin
                            state_s = state_r;
                        end
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_SWAP: begin
                active_s = shadow_r;
                state_s  = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        ongoing_s = (state_s == ST_DIRTY) || (state_s == ST_SWAP);
    end

    // State, tables and status flags; reset restores both tables to RstMap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            shadow_r  <= RstMap;
            active_r  <= RstMap;
            err_r     <= 1'b0;
            ongoing_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            shadow_r  <= shadow_s;
            active_r  <= active_s;
            err_r     <= err_s;
            ongoing_r <= ongoing_s;
        end
    end

    assign cfg_gnt_o        = gnt_s;
    assign cfg_err_o        = err_r;
    assign addr_map_o       = active_r;
    assign config_ongoing_o = ongoing_r;

endmodule
